// File: rtl/user_reg_intr_ctrl_pkg.sv
// Shared constants for the user register bank: register selects, CTRL bit
// positions and the interrupt handshake state encoding.
package user_reg_pkg;

  // Register select = byte offset [4:2]
  localparam logic [2:0] REG_ID         = 3'd0;  // 0x00
  localparam logic [2:0] REG_SCRATCH    = 3'd1;  // 0x04
  localparam logic [2:0] REG_CTRL       = 3'd2;  // 0x08
  localparam logic [2:0] REG_INT_STATUS = 3'd3;  // 0x0C
  localparam logic [2:0] REG_INT_MASK   = 3'd4;  // 0x10
  localparam logic [2:0] REG_TMR_LOAD   = 3'd5;  // 0x14
  localparam logic [2:0] REG_TMR_COUNT  = 3'd6;  // 0x18
  localparam logic [2:0] REG_USER_CTRL  = 3'd7;  // 0x1C

  localparam int CTRL_TMR_EN     = 0;
  localparam int CTRL_TMR_RELOAD = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_CLR = 2'd2
  } intr_state_e;

endpackage

// File: rtl/user_reg_intr_ctrl_if.sv
// User-side register bus and interrupt pair between the PCIe core (master)
// and the register bank (slave).
interface user_reg_intr_ctrl_if;
  // Handshake: wr/rd requests are one-cycle strobes with no backpressure;
  // every rd_req is answered by exactly one rd_ack (data valid) the next
  // cycle. intr_req is a level held until a one-cycle intr_ack is sampled.
  logic [19:0] user_addr_i;
  logic [31:0] user_data_i;
  logic        user_wr_req_i;
  logic        user_rd_req_i;
  logic [31:0] user_data_o;
  logic        user_rd_ack_o;
  logic        user_intr_req_o;
  logic        user_intr_ack_i;

  modport master (
    output user_addr_i, user_data_i, user_wr_req_i, user_rd_req_i, user_intr_ack_i,
    input  user_data_o, user_rd_ack_o, user_intr_req_o
  );

  modport slave (
    input  user_addr_i, user_data_i, user_wr_req_i, user_rd_req_i, user_intr_ack_i,
    output user_data_o, user_rd_ack_o, user_intr_req_o
  );
endinterface

// File: rtl/user_reg_intr_ctrl_timer.sv
// Programmable countdown: load on enable, decrement to zero, then either
// reload or hold at zero while flagging expiry every cycle it sits there enabled.
module user_reg_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_en,
  input  logic        i_reload,
  input  logic [31:0] i_load_val,
  output logic [31:0] o_count,
  output logic        o_expire
);

  logic [31:0] r_count;

  assign o_expire = i_en && (r_count == 32'd0);
  assign o_count  = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= i_load_val;
    end else if (o_expire) begin
      // Without reload the enable is cleared by the owner and the count rests at 0
      if (i_reload) r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count - 32'd1;
    end
  end

endmodule

// File: rtl/user_reg_intr_ctrl.sv
// User register bank with W1C interrupt status, mask, countdown timer and a
// request/ack interrupt handshake that waits for the source to clear before re-arming.
module user_reg_intr_ctrl
  import user_reg_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h5057_0001,
  parameter int          NUM_EVT  = 7
) (
  input  logic                 user_clk_i,
  input  logic                 user_reset_i,
  user_reg_intr_ctrl_if.slave  bus,
  input  logic [NUM_EVT-1:0]   evt_i,
  output logic [31:0]          user_ctrl_o,
  output intr_state_e          o_dbg_state
);

  localparam int SW = NUM_EVT + 1;

  logic          w_mapped, w_wr, w_ctrl_wr, w_tmr_start, w_tmr_expire, w_pending;
  logic [2:0]    w_sel;
  logic [31:0]   w_tmr_count, w_rd_mux;
  logic [SW-1:0] w_status_set, w_status_clr;
  logic          w_unused_addr;

  logic [31:0]   r_scratch, r_tmr_load, r_user_ctrl, r_rd_data;
  logic          r_tmr_en, r_tmr_reload, r_rd_ack;
  logic [SW-1:0] r_int_status, r_int_mask;
  intr_state_e   r_state, w_next_state;

  assign w_mapped      = (bus.user_addr_i[19:5] == 15'd0);
  assign w_sel         = bus.user_addr_i[4:2];
  assign w_unused_addr = &{1'b0, bus.user_addr_i[1:0]};
  assign w_wr          = bus.user_wr_req_i && w_mapped;
  assign w_ctrl_wr     = w_wr && (w_sel == REG_CTRL);
  assign w_tmr_start   = w_ctrl_wr && !r_tmr_en && bus.user_data_i[CTRL_TMR_EN];

  user_reg_timer u_timer (
    .clk        (user_clk_i),
    .rst        (user_reset_i),
    .i_start    (w_tmr_start),
    .i_en       (r_tmr_en),
    .i_reload   (r_tmr_reload),
    .i_load_val (r_tmr_load),
    .o_count    (w_tmr_count),
    .o_expire   (w_tmr_expire)
  );

  // Set is OR-ed after the clear so a same-cycle event beats a W1C
  assign w_status_set = {w_tmr_expire, evt_i};
  assign w_status_clr = (w_wr && (w_sel == REG_INT_STATUS)) ? bus.user_data_i[SW-1:0] : '0;
  assign w_pending    = |(r_int_status & r_int_mask);

  always_ff @(posedge user_clk_i or posedge user_reset_i) begin
    if (user_reset_i) begin
      r_scratch    <= '0;
      r_tmr_en     <= 1'b0;
      r_tmr_reload <= 1'b0;
      r_int_status <= '0;
      r_int_mask   <= '0;
      r_tmr_load   <= '0;
      r_user_ctrl  <= '0;
    end else begin
      r_int_status <= (r_int_status & ~w_status_clr) | w_status_set;
      if (w_ctrl_wr) begin
        r_tmr_en     <= bus.user_data_i[CTRL_TMR_EN];
        r_tmr_reload <= bus.user_data_i[CTRL_TMR_RELOAD];
      end else if (w_tmr_expire && !r_tmr_reload) begin
        r_tmr_en <= 1'b0;
      end
      if (w_wr) begin
        case (w_sel)
          REG_SCRATCH:   r_scratch   <= bus.user_data_i;
          REG_INT_MASK:  r_int_mask  <= bus.user_data_i[SW-1:0];
          REG_TMR_LOAD:  r_tmr_load  <= bus.user_data_i;
          REG_USER_CTRL: r_user_ctrl <= bus.user_data_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (w_mapped) begin
      case (w_sel)
        REG_ID:         w_rd_mux = ID_VALUE;
        REG_SCRATCH:    w_rd_mux = r_scratch;
        REG_CTRL:       w_rd_mux = {30'd0, r_tmr_reload, r_tmr_en};
        REG_INT_STATUS: w_rd_mux = 32'(r_int_status);
        REG_INT_MASK:   w_rd_mux = 32'(r_int_mask);
        REG_TMR_LOAD:   w_rd_mux = r_tmr_load;
        REG_TMR_COUNT:  w_rd_mux = w_tmr_count;
        REG_USER_CTRL:  w_rd_mux = r_user_ctrl;
        default:        w_rd_mux = '0;
      endcase
    end
  end

  // Read data is captured from pre-write state, so a same-cycle write is not seen
  always_ff @(posedge user_clk_i or posedge user_reset_i) begin
    if (user_reset_i) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_ack <= bus.user_rd_req_i;
      if (bus.user_rd_req_i) r_rd_data <= w_rd_mux;
    end
  end

  always_ff @(posedge user_clk_i or posedge user_reset_i) begin
    if (user_reset_i) r_state <= IDLE;
    else              r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_pending)           w_next_state = REQ;
      REQ:      if (bus.user_intr_ack_i) w_next_state = WAIT_CLR;
      WAIT_CLR: if (!w_pending)          w_next_state = IDLE;
      default:                           w_next_state = IDLE;
    endcase
  end

  assign bus.user_data_o     = r_rd_data;
  assign bus.user_rd_ack_o   = r_rd_ack;
  assign bus.user_intr_req_o = (r_state == REQ);
  assign user_ctrl_o         = r_user_ctrl;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_user_reg_intr_ctrl.sv
// Bench for user_reg_intr_ctrl: directed handshake/timer scenarios plus a
// randomized register-traffic run checked against a register-map model.
module tb_user_reg_intr_ctrl;
  import user_reg_pkg::*;

  localparam int          NUM_EVT = 7;
  localparam logic [31:0] ID_VAL  = 32'h5057_0001;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_EVT-1:0] evt = '0;
  logic [31:0]        user_ctrl;
  intr_state_e        dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  // Register-map model for the random run (timer kept disabled there)
  logic [31:0] m_scratch, m_load, m_user_ctrl;
  logic [1:0]  m_ctrl;
  logic [7:0]  m_status, m_mask;

  user_reg_intr_ctrl_if bus();

  user_reg_intr_ctrl #(.ID_VALUE(ID_VAL), .NUM_EVT(NUM_EVT)) dut (
    .user_clk_i   (clk),
    .user_reset_i (rst),
    .bus          (bus),
    .evt_i        (evt),
    .user_ctrl_o  (user_ctrl),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.user_addr_i     = '0;
    bus.user_data_i     = '0;
    bus.user_wr_req_i   = 1'b0;
    bus.user_rd_req_i   = 1'b0;
    bus.user_intr_ack_i = 1'b0;
    evt                 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_bus();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [19:0] a, input logic [31:0] d);
    bus.user_addr_i   = a;
    bus.user_data_i   = d;
    bus.user_wr_req_i = 1'b1;
    tick();
    bus.user_wr_req_i = 1'b0;
  endtask

  task automatic bus_read(input logic [19:0] a, output logic [31:0] d, output logic ack);
    bus.user_addr_i   = a;
    bus.user_rd_req_i = 1'b1;
    tick();
    bus.user_rd_req_i = 1'b0;
    ack = bus.user_rd_ack_o;
    d   = bus.user_data_o;
  endtask

  task automatic pulse_evt(input logic [NUM_EVT-1:0] e);
    evt = e;
    tick();
    evt = '0;
  endtask

  // ---------------- model ----------------
  function automatic logic [31:0] model_read(input logic [19:0] a);
    if (a[19:5] != 15'd0) return 32'd0;
    case (a[4:2])
      3'd0: return ID_VAL;
      3'd1: return m_scratch;
      3'd2: return {30'd0, m_ctrl};
      3'd3: return {24'd0, m_status};
      3'd4: return {24'd0, m_mask};
      3'd5: return m_load;
      3'd6: return 32'd0;
      default: return m_user_ctrl;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    logic ack;
    do_reset();
    n_checks++; if (bus.user_rd_ack_o !== 1'b0) $display("FAIL reset_ack: got %0b want 0", bus.user_rd_ack_o); else n_pass++;
    n_checks++; if (bus.user_data_o !== 32'd0) $display("FAIL reset_data: got %h want 0", bus.user_data_o); else n_pass++;
    n_checks++; if (bus.user_intr_req_o !== 1'b0) $display("FAIL reset_req: got %0b want 0", bus.user_intr_req_o); else n_pass++;
    n_checks++; if (user_ctrl !== 32'd0) $display("FAIL reset_user_ctrl: got %h want 0", user_ctrl); else n_pass++;
    n_checks++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
    bus_read(20'h00000, d, ack);
    n_checks++; if (ack !== 1'b1) $display("FAIL id_ack: got %0b want 1", ack); else n_pass++;
    n_checks++; if (d !== ID_VAL) $display("FAIL id_data: got %h want %h", d, ID_VAL); else n_pass++;
    tick();
    n_checks++; if (bus.user_rd_ack_o !== 1'b0) $display("FAIL ack_single: got %0b want 0", bus.user_rd_ack_o); else n_pass++;
    n_checks++; if (bus.user_data_o !== ID_VAL) $display("FAIL data_hold: got %h want %h", bus.user_data_o, ID_VAL); else n_pass++;
    bus_read(20'h00020, d, ack);
    n_checks++; if (ack !== 1'b1 || d !== 32'd0) $display("FAIL unmapped_rd_0x20: got ack %0b data %h want ack 1 data 0", ack, d); else n_pass++;
    bus_read(20'h80000, d, ack);
    n_checks++; if (ack !== 1'b1 || d !== 32'd0) $display("FAIL unmapped_rd_high: got ack %0b data %h want ack 1 data 0", ack, d); else n_pass++;
  endtask

  task automatic test_scratch();
    logic [31:0] d, v;
    logic ack;
    bus_write(20'h00004, 32'hA5A5_5A5A);
    bus_read(20'h00004, d, ack);
    n_checks++; if (d !== 32'hA5A5_5A5A) $display("FAIL scratch_rd: got %h want a5a55a5a", d); else n_pass++;
    bus.user_addr_i   = 20'h00004;
    bus.user_data_i   = 32'h1234_5678;
    bus.user_wr_req_i = 1'b1;
    bus.user_rd_req_i = 1'b1;
    tick();
    bus.user_wr_req_i = 1'b0;
    bus.user_rd_req_i = 1'b0;
    n_checks++; if (bus.user_rd_ack_o !== 1'b1 || bus.user_data_o !== 32'hA5A5_5A5A)
      $display("FAIL rw_same_cycle: got ack %0b data %h want ack 1 data a5a55a5a", bus.user_rd_ack_o, bus.user_data_o); else n_pass++;
    bus_read(20'h00004, d, ack);
    n_checks++; if (d !== 32'h1234_5678) $display("FAIL rw_after: got %h want 12345678", d); else n_pass++;
    bus_write(20'h00024, 32'hDEAD_BEEF);
    bus_read(20'h00004, d, ack);
    n_checks++; if (d !== 32'h1234_5678) $display("FAIL unmapped_wr_ignored: got %h want 12345678", d); else n_pass++;
    v = $urandom;
    bus_write(20'h0001C, v);
    n_checks++; if (user_ctrl !== v) $display("FAIL user_ctrl_o: got %h want %h", user_ctrl, v); else n_pass++;
  endtask

  task automatic test_intr();
    bus_write(20'h0000C, 32'hFF);
    bus_write(20'h00010, 32'h01);
    pulse_evt(7'h01);
    n_checks++; if (bus.user_intr_req_o !== 1'b0) $display("FAIL req_early: got %0b want 0", bus.user_intr_req_o); else n_pass++;
    tick();
    n_checks++; if (bus.user_intr_req_o !== 1'b1) $display("FAIL req_rise: got %0b want 1", bus.user_intr_req_o); else n_pass++;
    repeat (2) tick();
    n_checks++; if (bus.user_intr_req_o !== 1'b1) $display("FAIL req_level: got %0b want 1", bus.user_intr_req_o); else n_pass++;
    bus.user_intr_ack_i = 1'b1;
    tick();
    bus.user_intr_ack_i = 1'b0;
    n_checks++; if (bus.user_intr_req_o !== 1'b0 || dbg_state !== WAIT_CLR)
      $display("FAIL req_drop: got req %0b state %0d want req 0 state %0d", bus.user_intr_req_o, dbg_state, WAIT_CLR); else n_pass++;
    pulse_evt(7'h01);
    repeat (3) tick();
    n_checks++; if (bus.user_intr_req_o !== 1'b0) $display("FAIL no_rearm: got %0b want 0", bus.user_intr_req_o); else n_pass++;
    bus_write(20'h0000C, 32'h01);
    tick();
    n_checks++; if (dbg_state !== IDLE || bus.user_intr_req_o !== 1'b0)
      $display("FAIL back_to_idle: got state %0d req %0b want state %0d req 0", dbg_state, bus.user_intr_req_o, IDLE); else n_pass++;
    pulse_evt(7'h02);
    repeat (3) tick();
    n_checks++; if (bus.user_intr_req_o !== 1'b0) $display("FAIL masked_evt: got %0b want 0", bus.user_intr_req_o); else n_pass++;
    // Ack while idle must not block the next request
    bus.user_intr_ack_i = 1'b1;
    evt = 7'h01;
    tick();
    bus.user_intr_ack_i = 1'b0;
    evt = '0;
    tick();
    n_checks++; if (bus.user_intr_req_o !== 1'b1) $display("FAIL ack_in_idle: got %0b want 1", bus.user_intr_req_o); else n_pass++;
    bus.user_intr_ack_i = 1'b1;
    tick();
    bus.user_intr_ack_i = 1'b0;
    bus_write(20'h0000C, 32'hFF);
    repeat (2) tick();
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    logic ack;
    bus_write(20'h00010, 32'h0);
    pulse_evt(7'h08);
    bus.user_addr_i   = 20'h0000C;
    bus.user_data_i   = 32'h08;
    bus.user_wr_req_i = 1'b1;
    evt               = 7'h08;
    tick();
    bus.user_wr_req_i = 1'b0;
    evt               = '0;
    bus_read(20'h0000C, d, ack);
    n_checks++; if (d !== 32'h08) $display("FAIL set_wins: got %h want 00000008", d); else n_pass++;
    bus_write(20'h0000C, 32'h08);
    bus_read(20'h0000C, d, ack);
    n_checks++; if (d !== 32'h0) $display("FAIL w1c_clear: got %h want 0", d); else n_pass++;
  endtask

  task automatic test_timer_oneshot(input int load);
    logic [31:0] d;
    logic ack;
    bus_write(20'h0000C, 32'hFF);
    bus_write(20'h00014, 32'(load));
    bus_write(20'h00008, 32'h1);
    // Cycle k after the enable write: status shows expiry from k = load+1 on
    for (int k = 0; k <= load + 3; k++) begin
      bus_read(20'h0000C, d, ack);
      n_checks++; if (d[7] !== (k >= load + 1))
        $display("FAIL oneshot_status load=%0d k=%0d: got %0b want %0b", load, k, d[7], (k >= load + 1)); else n_pass++;
    end
    bus_read(20'h00008, d, ack);
    n_checks++; if (d !== 32'h0) $display("FAIL oneshot_en_clr: got %h want 0", d); else n_pass++;
    bus_read(20'h00018, d, ack);
    n_checks++; if (d !== 32'h0) $display("FAIL oneshot_count: got %h want 0", d); else n_pass++;
  endtask

  task automatic test_timer_reload(input int load);
    logic [31:0] d;
    logic ack;
    int last_k, frz;
    bus_write(20'h0000C, 32'hFF);
    bus_write(20'h00014, 32'(load));
    bus_write(20'h00008, 32'h3);
    last_k = 3 * (load + 1) + 1;
    for (int k = 0; k <= last_k; k++) begin
      bus_read(20'h00018, d, ack);
      n_checks++; if (d !== 32'(load - (k % (load + 1))))
        $display("FAIL reload_count load=%0d k=%0d: got %0d want %0d", load, k, d, load - (k % (load + 1))); else n_pass++;
    end
    // Disable written at cycle last_k+1; that cycle's decrement still happens
    frz = load - ((last_k + 2) % (load + 1));
    bus_write(20'h00008, 32'h0);
    for (int j = 0; j < 2; j++) begin
      bus_read(20'h00018, d, ack);
      n_checks++; if (d !== 32'(frz)) $display("FAIL freeze load=%0d j=%0d: got %0d want %0d", load, j, d, frz); else n_pass++;
    end
    bus_read(20'h0000C, d, ack);
    n_checks++; if (d[7] !== 1'b1) $display("FAIL reload_status: got %0b want 1", d[7]); else n_pass++;
  endtask

  task automatic test_random(input int n);
    logic [19:0]        a;
    logic [31:0]        d, e;
    logic [NUM_EVT-1:0] ev;
    logic               do_rd, do_wr, mapped;
    int                 op;
    do_reset();
    exp_q.delete();
    m_scratch = '0; m_load = '0; m_user_ctrl = '0; m_ctrl = '0; m_status = '0; m_mask = '0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = 20'($urandom);
        if (a[19:5] == 15'd0) a[19] = 1'b1;
      end else begin
        a = {15'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      end
      mapped = (a[19:5] == 15'd0);
      op     = $urandom_range(0, 2);
      do_rd  = (op != 1);
      do_wr  = (op != 0);
      d      = $urandom;
      if (mapped && a[4:2] == 3'd2) d[0] = 1'b0;
      ev = 7'($urandom) & 7'($urandom) & 7'($urandom);
      if (do_rd) exp_q.push_back(model_read(a));
      bus.user_addr_i   = a;
      bus.user_data_i   = d;
      bus.user_wr_req_i = do_wr;
      bus.user_rd_req_i = do_rd;
      evt               = ev;
      tick();
      idle_bus();
      n_checks++; if (bus.user_rd_ack_o !== do_rd) $display("FAIL rand_ack i=%0d: got %0b want %0b", i, bus.user_rd_ack_o, do_rd); else n_pass++;
      if (bus.user_rd_ack_o === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++; if (bus.user_data_o !== e) $display("FAIL rand_rd i=%0d addr=%h: got %h want %h", i, a, bus.user_data_o, e); else n_pass++;
      end
      if (do_wr && mapped) begin
        case (a[4:2])
          3'd1: m_scratch   = d;
          3'd2: m_ctrl      = d[1:0];
          3'd3: m_status    = m_status & ~d[7:0];
          3'd4: m_mask      = d[7:0];
          3'd5: m_load      = d;
          3'd7: m_user_ctrl = d;
          default: ;
        endcase
      end
      m_status[NUM_EVT-1:0] = m_status[NUM_EVT-1:0] | ev;
      n_checks++; if (user_ctrl !== m_user_ctrl) $display("FAIL rand_user_ctrl i=%0d: got %h want %h", i, user_ctrl, m_user_ctrl); else n_pass++;
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL rand_leftover: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic ack;
    bus_write(20'h00004, 32'hCAFE_F00D);
    bus_write(20'h0001C, 32'h0000_00FF);
    bus_write(20'h00014, 32'd9);
    bus_write(20'h0000C, 32'hFF);
    bus_write(20'h00010, 32'h01);
    pulse_evt(7'h01);
    tick();
    n_checks++; if (bus.user_intr_req_o !== 1'b1) $display("FAIL mid_req_before: got %0b want 1", bus.user_intr_req_o); else n_pass++;
    bus.user_addr_i   = 20'h00004;
    bus.user_rd_req_i = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.user_intr_req_o !== 1'b0 || bus.user_rd_ack_o !== 1'b0 || bus.user_data_o !== 32'd0 || user_ctrl !== 32'd0)
      $display("FAIL mid_reset_outputs: got req %0b ack %0b data %h uctrl %h want all 0",
               bus.user_intr_req_o, bus.user_rd_ack_o, bus.user_data_o, user_ctrl); else n_pass++;
    tick();
    bus.user_rd_req_i = 1'b0;
    n_checks++; if (bus.user_rd_ack_o !== 1'b0) $display("FAIL mid_no_ack_in_reset: got %0b want 0", bus.user_rd_ack_o); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (bus.user_rd_ack_o !== 1'b0 || dbg_state !== IDLE)
      $display("FAIL mid_no_ack_after: got ack %0b state %0d want ack 0 state %0d", bus.user_rd_ack_o, dbg_state, IDLE); else n_pass++;
    bus_read(20'h00000, d, ack);
    n_checks++; if (d !== ID_VAL) $display("FAIL mid_id: got %h want %h", d, ID_VAL); else n_pass++;
    for (int i = 1; i < 8; i++) begin
      bus_read(20'(i * 4), d, ack);
      n_checks++; if (ack !== 1'b1 || d !== 32'd0) $display("FAIL mid_reg_reset off=%h: got ack %0b data %h want ack 1 data 0", i * 4, ack, d); else n_pass++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_bus();
    test_reset();
    test_scratch();
    test_intr();
    test_set_wins();
    test_timer_oneshot(4);
    test_timer_oneshot($urandom_range(0, 8));
    test_timer_reload(4);
    test_timer_reload(0);
    test_timer_reload($urandom_range(1, 6));
    test_random(400);
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
